conv_maxpool_sink: RTL and testbench
====================================

Name: conv_maxpool_sink

Overview:
- Receive end of the convolution engine's result stream: consumes the serial `out`/`out_en` pulse stream (row-major, R×R results, arbitrary gaps between pulses).
- Performs optional ReLU then 2×2 stride-2 max pooling on the fly using a half-row line buffer.
- Emits (R/2)² pooled values as single-cycle pulses, then asserts done.
- Sits directly downstream of the conv block, feeding the next CNN layer or the result capture logic.

Parameters:
- R, 12, conv output side length (N−M+1); must be even and ≥2.
- DW, 13, signed data width of input and output samples.
- RELU, 0, 1 = clamp negative inputs to 0 before pooling; 0 = pass through.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DW  signed conv result; valid only when in_en=1.
- in_en  in  1  single-cycle strobe marking one conv result.
- in_done  in  1  conv engine finished (level).
- out_data  out  DW  signed pooled result.
- out_en  out  1  one-cycle strobe qualifying out_data.
- done  out  1  all (R/2)² outputs emitted; sticky until rst.
- err  out  1  sticky; in_done seen high before all R×R inputs received.

Behaviour:
- Reset: rst at a clock edge forces these values, whether idle or mid-frame:
  - out_data=0, out_en=0, done=0, err=0.
  - col=0, row=0, hold=0, state=S_RUN.
  - Line buffer contents are don't-care (always written before read).
- FSM: two states.
  - S_RUN: accepts in_en.
  - S_DONE: in_en ignored, counters frozen, done=1.
- Preprocess: x = (RELU && in_data<0) ? 0 : in_data. All compares are signed DW-bit; no width growth.
- Counters: col 0..R−1 advances on each accepted in_en. On wrap, col→0 and row increments.
- Line buffer: lb[0..R/2−1].
- Per accepted in_en in S_RUN:
  - col even: hold <= x.
  - row even, col odd: lb[col>>1] <= max(hold, x).
  - row odd, col odd: out_data <= max(lb[col>>1], max(hold, x)); out_en <= 1 at the same edge.
- Latency: out_en is high in the cycle after the in_en that completes the 2×2 window. It is held for exactly one cycle, then returns to 0.
- Back-to-back in_en on consecutive cycles must be supported: one output per completed window, no stalls.
- Completion: the in_en at row=R−1, col=R−1 emits the final pulse.
  - At that same edge, state→S_DONE and done<=1.
  - done and out_en are both high in that cycle.
- in_en while in S_DONE: no output, no counter change.
- err:
  - Set at any edge where in_done=1 and state=S_RUN.
  - Not set if in_done rises at or after the final accepted in_en's edge.
  - Cleared only by rst.
- out_data holds its last value between pulses.

Test Plan:
1. R=4, RELU=0, inputs 1..16 row-major, one in_en every 3 cycles.
   - Expect out_en pulses with values 6, 8, 14, 16, each one cycle after inputs #6, #8, #14, #16.
   - done rises with the pulse for 16.
2. R=4, inputs 1..16 on consecutive cycles (in_en held high 16 cycles).
   - Expect the same 4 values, exactly 4 single-cycle out_en pulses.
3. R=4, all inputs −5.
   - RELU=0 → four outputs of −5.
   - RELU=1 → four outputs of 0.
4. R=12 default, input value = row·12+col.
   - Expect 36 outputs equal to (2i+1)·12+(2j+1), with out_en count exactly 36 and done=1 afterwards.
   - 5 extra in_en after done → no out_en, out_data unchanged.
5. R=4, feed 7 inputs, pulse rst, then feed a fresh 1..16 frame.
   - Expect no output from the aborted frame's state; outputs 6, 8, 14, 16; err=0.
6. R=4, feed 10 inputs then raise in_done.
   - Expect err=1 next cycle, sticky.
   - Normal completion with in_done raised 3 cycles after the last input → err=0.

Source files
------------

// File: rtl/conv_maxpool_sink.sv
// conv_maxpool_sink
// Receive end of the convolution result stream. Applies optional ReLU, then
// 2x2 stride-2 max pooling on the fly using a half-row line buffer. Emits
// (R/2)^2 pooled results as single-cycle strobes, then raises a sticky done.
// err flags an in_done level seen while the frame is still incomplete.
module conv_maxpool_sink #(
    parameter int R    = 12,
    parameter int DW   = 13,
    parameter int RELU = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_en,
    input  logic                 in_done,
    output logic signed [DW-1:0] out_data,
    output logic                 out_en,
    output logic                 done,
    output logic                 err
);

    localparam int HALF = (R / 2 > 0) ? R / 2 : 1;
    localparam int CW   = (R > 1) ? $clog2(R) : 1;
    localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(R - 1);

    typedef enum logic {
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_col;
    logic [CW-1:0]        r_row;
    logic signed [DW-1:0] r_hold;
    logic signed [DW-1:0] r_lb [HALF];

    logic                 w_accept;
    logic                 w_last;
    logic [LW-1:0]        w_lbidx;
    logic signed [DW-1:0] w_x;
    logic signed [DW-1:0] w_hx;
    logic signed [DW-1:0] w_lbv;
    logic signed [DW-1:0] w_win;

    assign w_accept = in_en && (r_state == S_RUN);
    assign w_last   = (r_row == LAST) && (r_col == LAST);
    assign w_lbidx  = LW'(r_col >> 1);

    // Preprocess and pooling comparators: horizontal pair, then vertical pair.
    always_comb begin
        w_x   = (RELU != 0 && in_data[DW-1]) ? '0 : in_data;
        w_hx  = (r_hold > w_x) ? r_hold : w_x;
        w_lbv = r_lb[w_lbidx];
        w_win = (w_lbv > w_hx) ? w_lbv : w_hx;
    end

    // Line buffer: even rows store the horizontal max of each column pair.
    always_ff @(posedge clk) begin
        if (w_accept && !r_row[0] && r_col[0]) begin
            r_lb[w_lbidx] <= w_hx;
        end
    end

    // Control FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_col    <= '0;
            r_row    <= '0;
            r_hold   <= '0;
            out_data <= '0;
            out_en   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            out_en <= 1'b0;
            if (in_done && r_state == S_RUN) begin
                err <= 1'b1;
            end
            case (r_state)
                S_RUN: begin
                    if (in_en) begin
                        if (!r_col[0]) begin
                            r_hold <= w_x;
                        end
                        if (r_row[0] && r_col[0]) begin
                            out_data <= w_win;
                            out_en   <= 1'b1;
                        end
                        if (w_last) begin
                            r_col   <= '0;
                            r_row   <= '0;
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else if (r_col == LAST) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_maxpool_sink.sv
// tb_conv_maxpool_sink
// Directed bench: two R=4 instances (ReLU off/on) share one input stream,
// an R=12 instance has its own. Output strobes are logged into queues.
module tb_conv_maxpool_sink;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic signed [12:0] in_data = '0;
    logic               in_en   = 1'b0;
    logic               in_done = 1'b0;
    logic signed [12:0] in12_data = '0;
    logic               in12_en   = 1'b0;
    logic               in12_done = 1'b0;

    logic signed [12:0] o4_data, o4r_data, o12_data;
    logic               o4_en, o4r_en, o12_en;
    logic               d4, d4r, d12;
    logic               e4, e4r, e12;

    int n_checks = 0;
    int n_pass   = 0;

    int q4[$];
    int q4r[$];
    int q12[$];

    int exp4[4] = '{6, 8, 14, 16};

    always #5 clk = ~clk;

    conv_maxpool_sink #(.R(4), .DW(13), .RELU(0)) u4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en), .in_done(in_done),
        .out_data(o4_data), .out_en(o4_en), .done(d4), .err(e4)
    );

    conv_maxpool_sink #(.R(4), .DW(13), .RELU(1)) u4r (
        .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en), .in_done(in_done),
        .out_data(o4r_data), .out_en(o4r_en), .done(d4r), .err(e4r)
    );

    conv_maxpool_sink #(.R(12), .DW(13), .RELU(0)) u12 (
        .clk(clk), .rst(rst), .in_data(in12_data), .in_en(in12_en), .in_done(in12_done),
        .out_data(o12_data), .out_en(o12_en), .done(d12), .err(e12)
    );

    // Log every output strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (o4_en)  q4.push_back(int'(o4_data));
        if (o4r_en) q4r.push_back(int'(o4r_data));
        if (o12_en) q12.push_back(int'(o12_data));
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send4(input int v, input int idle);
        in_en   = 1'b1;
        in_data = 13'(v);
        @(negedge clk);
        in_en = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic send12(input int v, input int idle);
        in12_en   = 1'b1;
        in12_data = 13'(v);
        @(negedge clk);
        in12_en = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic check_q4(input string tag, input int e0, input int e1,
                            input int e2, input int e3, input int use_relu);
        int ev[4];
        int n;
        ev = '{e0, e1, e2, e3};
        n = use_relu ? q4r.size() : q4.size();
        check({tag, "_count"}, n, 4);
        for (int i = 0; i < 4; i++) begin
            if (use_relu)
                check({tag, "_val"}, (i < q4r.size()) ? q4r[i] : -9999, ev[i]);
            else
                check({tag, "_val"}, (i < q4.size()) ? q4[i] : -9999, ev[i]);
        end
    endtask

    initial begin
        do_reset();
        check("rst_out_data", int'(o4_data), 0);
        check("rst_out_en", int'(o4_en), 0);
        check("rst_done", int'(d4), 0);
        check("rst_err", int'(e4), 0);
        check("rst12_done", int'(d12), 0);

        // 1: sparse stream, exact latency and done timing
        for (int k = 1; k <= 16; k++) begin
            int pulse;
            pulse = (k == 6 || k == 8 || k == 14 || k == 16) ? 1 : 0;
            send4(k, 0);
            check("t1_out_en", int'(o4_en), pulse);
            if (pulse == 1) check("t1_out_data", int'(o4_data), k);
            check("t1_done", int'(d4), (k == 16) ? 1 : 0);
            repeat (2) @(negedge clk);
        end
        check("t1_out_en_drop", int'(o4_en), 0);
        check("t1_hold_data", int'(o4_data), 16);
        check("t1_done_sticky", int'(d4), 1);
        check("t1_err", int'(e4), 0);
        check_q4("t1_q", 6, 8, 14, 16, 0);

        // 2: back-to-back stream
        do_reset();
        q4.delete(); q4r.delete();
        for (int k = 1; k <= 16; k++) send4(k, 0);
        repeat (3) @(negedge clk);
        check_q4("t2_q", exp4[0], exp4[1], exp4[2], exp4[3], 0);
        check("t2_done", int'(d4), 1);

        // 3: all negative, ReLU off vs on
        do_reset();
        q4.delete(); q4r.delete();
        for (int k = 1; k <= 16; k++) send4(-5, 0);
        repeat (3) @(negedge clk);
        check_q4("t3_norelu", -5, -5, -5, -5, 0);
        check_q4("t3_relu", 0, 0, 0, 0, 1);

        // 4: R=12 frame with occasional gaps, then extra inputs after done
        do_reset();
        q12.delete();
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++)
                send12(r * 12 + c, ((r * 12 + c) % 7 == 3) ? 1 : 0);
        repeat (3) @(negedge clk);
        check("t4_count", q12.size(), 36);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                check("t4_val", (i * 6 + j < q12.size()) ? q12[i * 6 + j] : -9999,
                      (2 * i + 1) * 12 + (2 * j + 1));
        check("t4_done", int'(d12), 1);
        check("t4_err", int'(e12), 0);
        for (int k = 0; k < 5; k++) send12(1000 + k, 0);
        repeat (3) @(negedge clk);
        check("t4_extra_count", q12.size(), 36);
        check("t4_extra_data", int'(o12_data), 143);
        check("t4_extra_done", int'(d12), 1);

        // 5: abort mid-frame with reset, then a clean frame
        do_reset();
        for (int k = 1; k <= 7; k++) send4(k, 0);
        do_reset();
        check("t5_rst_data", int'(o4_data), 0);
        check("t5_rst_en", int'(o4_en), 0);
        check("t5_rst_done", int'(d4), 0);
        q4.delete(); q4r.delete();
        for (int k = 1; k <= 16; k++) send4(k, 0);
        repeat (3) @(negedge clk);
        check_q4("t5_q", 6, 8, 14, 16, 0);
        check("t5_err", int'(e4), 0);

        // 6: premature in_done sets err; late in_done does not
        do_reset();
        for (int k = 1; k <= 10; k++) send4(k, 0);
        check("t6_err_pre", int'(e4), 0);
        in_done = 1'b1;
        @(negedge clk);
        check("t6_err_set", int'(e4), 1);
        in_done = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_err_sticky", int'(e4), 1);
        do_reset();
        check("t6_err_clr", int'(e4), 0);
        for (int k = 1; k <= 16; k++) send4(k, 0);
        repeat (2) @(negedge clk);
        in_done = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_err_late", int'(e4), 0);
        check("t6_done", int'(d4), 1);
        in_done = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
